// File: rtl/checkpoint_seq_monitor_pkg.sv
// Shared types and constants for the checkpoint sequence monitor.
package checkpoint_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4
    } seq_state_t;

    // fail_code encodings
    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
    localparam logic [1:0] FAIL_ORDER   = 2'd2;

endpackage

// File: rtl/checkpoint_seq_monitor_probe_stable_filter.sv
// Registers the probe bus and emits a single strobe once the registered
// value has held for STABLE consecutive cycles. The strobe does not repeat
// until the value changes, so a steady value is evaluated exactly once.
module probe_stable_filter
    import checkpoint_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STABLE = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_probe,
    output logic [WIDTH-1:0] o_probe_q,
    output logic             o_stb
);

    // Counter saturates one past STABLE so the strobe fires only once
    localparam int CW = $clog2(STABLE + 2);
    localparam logic [CW-1:0] CNT_STB = CW'(STABLE);
    localparam logic [CW-1:0] CNT_SAT = CW'(STABLE + 1);

    logic [WIDTH-1:0] r_probe_q;
    logic [CW-1:0]    r_cnt;

    // Capture probe; a new value restarts the hold count at one cycle held
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_probe_q <= '0;
            r_cnt     <= '0;
        end else if (i_probe != r_probe_q) begin
            r_probe_q <= i_probe;
            r_cnt     <= CW'(1);
        end else if (r_cnt != CNT_SAT) begin
            r_cnt     <= r_cnt + CW'(1);
        end
    end

    assign o_probe_q = r_probe_q;
    assign o_stb     = (r_cnt == CNT_STB);

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint sequence monitor: compares each stable probe value against a
// programmable expected table and reports pass / fail / timeout.
// Optional macro SEQ_STRICT_ORDER_EN: an out-of-order hit on a later table
// entry fails the check with FAIL_ORDER instead of being ignored.
module checkpoint_seq_monitor
    import checkpoint_seq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT_W = 24,
    parameter int STABLE    = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       exp_we,
    input  logic [$clog2(DEPTH)-1:0]   exp_addr,
    input  logic [WIDTH-1:0]           exp_wdata,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic [TIMEOUT_W-1:0]       timeout_cycles,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           probe_i,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [1:0]                 fail_code,
    output logic [$clog2(DEPTH):0]     step_idx,
    output logic                       match_stb
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0]     r_table [DEPTH];
    seq_state_t           r_state;
    logic                 r_busy;
    logic                 r_pass;
    logic                 r_fail;
    logic [1:0]           r_fail_code;
    logic [LW-1:0]        r_step_idx;
    logic                 r_match_stb;
    logic [LW-1:0]        r_len;
    logic [TIMEOUT_W-1:0] r_tcnt;

    logic [WIDTH-1:0]     w_probe_q;
    logic                 w_stb;
    logic [WIDTH-1:0]     w_exp_word;
    logic                 w_hit;
    logic [LW-1:0]        w_step_nxt;
    logic [LW-1:0]        w_len_eff;
    logic [TIMEOUT_W-1:0] w_tcnt_inc;
    logic                 w_timeout;
    logic                 w_order_hit;

    probe_stable_filter #(
        .WIDTH  (WIDTH),
        .STABLE (STABLE)
    ) u_filter (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_probe   (probe_i),
        .o_probe_q (w_probe_q),
        .o_stb     (w_stb)
    );

    // Step decode: expected word, next index, clamped length, timeout test
    always_comb begin
        w_exp_word = r_table[r_step_idx[AW-1:0]];
        w_hit      = w_stb && (w_probe_q == w_exp_word);
        w_step_nxt = r_step_idx + LW'(1);
        w_len_eff  = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
        w_tcnt_inc = (r_tcnt == '1) ? r_tcnt : r_tcnt + TIMEOUT_W'(1);
        w_timeout  = (timeout_cycles != '0) && (w_tcnt_inc >= timeout_cycles);
    end

`ifdef SEQ_STRICT_ORDER_EN
    // Flag a stable value that belongs to a later, not-yet-reached step
    always_comb begin
        w_order_hit = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (w_stb && (LW'(j) > r_step_idx) && (LW'(j) < r_len) &&
                (r_table[j] == w_probe_q))
                w_order_hit = 1'b1;
        end
    end
`else
    assign w_order_hit = 1'b0;
`endif

    // Expected table; writes are dropped while a check is running
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else if (exp_we && !r_busy) begin
            r_table[exp_addr] <= exp_wdata;
        end
    end

    // Sequencer FSM with registered status outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= FAIL_NONE;
            r_step_idx  <= '0;
            r_match_stb <= 1'b0;
            r_len       <= '0;
            r_tcnt      <= '0;
        end else begin
            r_match_stb <= 1'b0;
            if (abort) begin
                // Status and progress are kept for readback after an abort
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_PASS, ST_FAIL: begin
                        if (start) begin
                            r_state     <= ST_ARM;
                            r_busy      <= 1'b1;
                            r_pass      <= 1'b0;
                            r_fail      <= 1'b0;
                            r_fail_code <= FAIL_NONE;
                            r_step_idx  <= '0;
                            r_tcnt      <= '0;
                            r_len       <= w_len_eff;
                        end
                    end
                    ST_ARM: begin
                        r_tcnt <= '0;
                        if (r_len == '0) begin
                            r_state <= ST_PASS;
                            r_busy  <= 1'b0;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // A match takes priority over a same-cycle timeout
                        if (w_hit) begin
                            r_step_idx  <= w_step_nxt;
                            r_match_stb <= 1'b1;
                            r_tcnt      <= '0;
                            if (w_step_nxt == r_len) begin
                                r_state <= ST_PASS;
                                r_busy  <= 1'b0;
                                r_pass  <= 1'b1;
                            end
                        end else if (w_order_hit) begin
                            r_state     <= ST_FAIL;
                            r_busy      <= 1'b0;
                            r_fail      <= 1'b1;
                            r_fail_code <= FAIL_ORDER;
                        end else if (w_timeout) begin
                            r_state     <= ST_FAIL;
                            r_busy      <= 1'b0;
                            r_fail      <= 1'b1;
                            r_fail_code <= FAIL_TIMEOUT;
                        end else begin
                            r_tcnt <= w_tcnt_inc;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_code = r_fail_code;
    assign step_idx  = r_step_idx;
    assign match_stb = r_match_stb;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed bench for checkpoint_seq_monitor (WIDTH=16, DEPTH=8, STABLE=2).
module tb_checkpoint_seq_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exp_we = 1'b0;
    logic [2:0]  exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    logic [3:0]  seq_len = '0;
    logic [23:0] timeout_cycles = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] probe_i = '0;
    logic        busy, pass, fail, match_stb;
    logic [1:0]  fail_code;
    logic [3:0]  step_idx;

    int total = 0;
    int bad   = 0;
    int stb_cnt = 0;

    checkpoint_seq_monitor #(
        .WIDTH(16), .DEPTH(8), .TIMEOUT_W(24), .STABLE(2)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_wdata(exp_wdata),
        .seq_len(seq_len), .timeout_cycles(timeout_cycles),
        .start(start), .abort(abort), .probe_i(probe_i),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .step_idx(step_idx), .match_stb(match_stb)
    );

    always #5 clk = ~clk;

    // Inputs change on negedges; outputs are sampled on negedges.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        exp_addr = a; exp_wdata = d; exp_we = 1'b1;
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        probe_i = v;
        repeat (n) begin
            @(negedge clk);
            if (match_stb === 1'b1) stb_cnt++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL rst_pass got=%0h exp=0", pass); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL rst_fail got=%0h exp=0", fail); end
        total++; if (fail_code !== 2'd0) begin bad++; $display("FAIL rst_code got=%0h exp=0", fail_code); end
        total++; if (step_idx !== 4'd0) begin bad++; $display("FAIL rst_step got=%0h exp=0", step_idx); end
        total++; if (match_stb !== 1'b0) begin bad++; $display("FAIL rst_stb got=%0h exp=0", match_stb); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        wr(3'd0, 16'hAB40); wr(3'd1, 16'hAB41); wr(3'd2, 16'hAB51);
        seq_len = 4'd3; timeout_cycles = '0;
        stb_cnt = 0;
        pulse_start();
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0h exp=1", busy); end
        hold(16'hAB40, 10); hold(16'hAB41, 10); hold(16'hAB51, 10);
        total++; if (stb_cnt !== 3) begin bad++; $display("FAIL basic_stbcnt got=%0d exp=3", stb_cnt); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL basic_pass got=%0h exp=1", pass); end
        total++; if (step_idx !== 4'd3) begin bad++; $display("FAIL basic_step got=%0h exp=3", step_idx); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL basic_fail got=%0h exp=0", fail); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%0h exp=0", busy); end
    endtask

    task automatic test_ignore();
        pulse_start();
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL ign_passclr got=%0h exp=0", pass); end
        hold(16'hAB40, 10); hold(16'h1234, 10); hold(16'hAB41, 10); hold(16'hAB51, 10);
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL ign_pass got=%0h exp=1", pass); end
        total++; if (step_idx !== 4'd3) begin bad++; $display("FAIL ign_step got=%0h exp=3", step_idx); end
    endtask

    task automatic test_order();
        pulse_start();
        hold(16'hAB40, 10); hold(16'hAB51, 10);
        total++; if (step_idx !== 4'd1) begin bad++; $display("FAIL ord_step got=%0h exp=1", step_idx); end
`ifdef SEQ_STRICT_ORDER_EN
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL ord_fail got=%0h exp=1", fail); end
        total++; if (fail_code !== 2'd2) begin bad++; $display("FAIL ord_code got=%0h exp=2", fail_code); end
`else
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL ord_fail got=%0h exp=0", fail); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ord_busy got=%0h exp=1", busy); end
`endif
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0h exp=0", busy); end
        total++; if (step_idx !== 4'd1) begin bad++; $display("FAIL abort_step got=%0h exp=1", step_idx); end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        timeout_cycles = 24'd100;
        hold(16'h0000, 6);
        pulse_start();
        probe_i = 16'hAB40;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (match_stb === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL to_match got=0 exp=1"); end
        repeat (99) @(negedge clk);
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL to_early got=%0h exp=0", fail); end
        @(negedge clk);
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL to_fail got=%0h exp=1", fail); end
        total++; if (fail_code !== 2'd1) begin bad++; $display("FAIL to_code got=%0h exp=1", fail_code); end
        total++; if (step_idx !== 4'd1) begin bad++; $display("FAIL to_step got=%0h exp=1", step_idx); end
        timeout_cycles = '0;
    endtask

    task automatic test_glitch();
        seq_len = 4'd2;
        hold(16'h0000, 6);
        pulse_start();
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL gl_failclr got=%0h exp=0", fail); end
        hold(16'hAB40, 10);
        hold(16'hAB41, 1); hold(16'hAB40, 10);
        total++; if (step_idx !== 4'd1) begin bad++; $display("FAIL gl_step got=%0h exp=1", step_idx); end
        hold(16'hAB41, 2); hold(16'hAB40, 10);
        total++; if (step_idx !== 4'd2) begin bad++; $display("FAIL gl_match got=%0h exp=2", step_idx); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL gl_pass got=%0h exp=1", pass); end
    endtask

    task automatic test_len0();
        seq_len = 4'd0;
        pulse_start();
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL l0_arm got=%0h exp=0", pass); end
        @(negedge clk);
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL l0_pass got=%0h exp=1", pass); end
        total++; if (step_idx !== 4'd0) begin bad++; $display("FAIL l0_step got=%0h exp=0", step_idx); end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
        seq_len = 4'd15;
        hold(16'h0000, 6);
        stb_cnt = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) hold(16'h1000 + 16'(i), 6);
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL cl_early got=%0h exp=0", pass); end
        hold(16'h1007, 6);
        total++; if (stb_cnt !== 8) begin bad++; $display("FAIL cl_stbcnt got=%0d exp=8", stb_cnt); end
        total++; if (step_idx !== 4'd8) begin bad++; $display("FAIL cl_step got=%0h exp=8", step_idx); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL cl_pass got=%0h exp=1", pass); end
    endtask

    task automatic test_busy_write();
        seq_len = 4'd2;
        hold(16'h0000, 6);
        pulse_start();
        hold(16'h1000, 8);
        wr(3'd1, 16'hBEEF);
        hold(16'h1001, 8);
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL bw_pass got=%0h exp=1", pass); end
        total++; if (step_idx !== 4'd2) begin bad++; $display("FAIL bw_step got=%0h exp=2", step_idx); end
    endtask

    task automatic test_async_reset();
        hold(16'h0000, 6);
        pulse_start();
        hold(16'h1000, 8);
        total++; if (step_idx !== 4'd1) begin bad++; $display("FAIL ar_pre got=%0h exp=1", step_idx); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%0h exp=0", busy); end
        total++; if (step_idx !== 4'd0) begin bad++; $display("FAIL ar_step got=%0h exp=0", step_idx); end
        total++; if (pass !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL ar_flags got=%0h%0h exp=00", pass, fail); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore();
        test_order();
        test_timeout();
        test_glitch();
        test_len0();
        test_clamp();
        test_busy_write();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/checkpoint_seq_monitor.md
# checkpoint_seq_monitor

On-chip checkpoint sequence monitor for the user project area. It watches a WIDTH-bit probe bus, typically the firmware checkpoint word driven onto mprj_io[31:16] or a logic-analyzer slice. It compares each new stable value against a programmable expected sequence of up to DEPTH entries, and reports pass, fail, or timeout. It replaces single-pattern, testbench-only waits with a synthesizable, multi-step checker that can be read back over the logic analyzer.

## Interface
- WIDTH, 16: probe and expected-word width.
- DEPTH, 8: expected-sequence table entries (power of 2, ≥2).
- TIMEOUT_W, 24: per-step timeout counter width.
- STABLE, 2: consecutive cycles the probe must hold before it is evaluated (≥1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- exp_we  in  1  table write strobe.
- exp_addr  in  $clog2(DEPTH)  table write address.
- exp_wdata  in  WIDTH  expected word.
- seq_len  in  $clog2(DEPTH)+1  number of steps to check.
- timeout_cycles  in  TIMEOUT_W  per-step limit; 0 disables the timeout.
- start  in  1  begin a check (pulse).
- abort  in  1  return to IDLE.
- probe_i  in  WIDTH  observed checkpoint bus (asynchronous to the design, already synchronized upstream).
- busy  out  1  high in ARM and WAIT.
- pass  out  1  sticky, sequence completed.
- fail  out  1  sticky, check failed.
- fail_code  out  2  0 none, 1 timeout, 2 order.
- step_idx  out  $clog2(DEPTH)+1  number of steps matched so far.
- match_stb  out  1  one-cycle pulse per matched step.

## Operation
- The expected table is a DEPTH×WIDTH register array.
  - Writes take effect only when busy=0; they are silently dropped while busy.
- Filter: probe_i is registered into probe_q.
  - A hold counter clears whenever probe_q changes.
  - stb pulses for one cycle when probe_q has been equal for STABLE consecutive cycles, and not again until probe_q changes.
- FSM states: IDLE, ARM, WAIT, PASS, FAIL.
- IDLE→ARM on start.
  - pass, fail, fail_code, step_idx and the timeout counter clear.
  - The effective length is min(seq_len, DEPTH).
- ARM→PASS when the effective length is 0; otherwise ARM→WAIT.
- WAIT, on stb with value == table[step_idx]: step_idx+1 and match_stb pulses.
  - If step_idx reaches the length → PASS.
- WAIT, on stb with a non-matching value: ignored (default build).
- WAIT, when the timeout counter reaches timeout_cycles (≠0) → FAIL with fail_code=1.
  - The counter clears on entry to WAIT and on every match, and saturates.
- A match and a timeout in the same cycle: the match wins.
- PASS and FAIL hold until start (→ARM) or abort (→IDLE; pass, fail and fail_code are kept).
- start while busy is ignored. abort in any state → IDLE; step_idx is kept.
- Duplicate consecutive expected words need a probe change between them. A value held steady matches only once.

## Timing
- Reset values: busy=0, pass=0, fail=0, fail_code=0, step_idx=0, match_stb=0. FSM=IDLE, table=0.
- start sampled at edge t → ARM at t+1 → WAIT at t+2.
- A probe value captured into probe_q at edge k produces stb at edge k+STABLE-1 and the step_idx/match_stb update at edge k+STABLE.
- pass/fail assert in the same cycle as the final match or the timeout decision.
- A reset asserted mid-check returns everything to reset values immediately.

## Configuration
- SEQ_STRICT_ORDER_EN defined: in WAIT, a stb value equal to any table[j] with step_idx < j < length (and not equal to table[step_idx]) → FAIL with fail_code=2.
- Without the macro: fail_code 2 is never produced, and non-matching values are always ignored.

## Structure
- Package checkpoint_seq_pkg holds:
  - the FSM state enum;
  - the fail_code constants FAIL_NONE, FAIL_TIMEOUT, FAIL_ORDER.
- Sub-module probe_stable_filter (probe_q register, hold counter, stb generation), parameterised by WIDTH and STABLE.

## Test plan
- Table {AB40, AB41, AB51}, seq_len=3, timeout 0, probe walks AB40→AB41→AB51 each held 10 cycles → three match_stb pulses, pass=1, step_idx=3, fail=0.
- Same table, probe sequence AB40, 1234, AB41, AB51 → 1234 is ignored, pass=1 (default build); with SEQ_STRICT_ORDER_EN, AB40→AB51 skipping AB41 → fail=1, fail_code=2, step_idx=1.
- timeout_cycles=100, probe stuck at AB40 after the first match → fail=1 and fail_code=1 exactly 100 cycles after the match.
- STABLE=2, probe glitches to AB41 for 1 cycle then returns to AB40 → no match; AB41 held 2 cycles → match.
- seq_len=0 with start → pass two edges later. seq_len=15 with DEPTH=8 → clamped, pass after 8 matches.
- Reset asserted while in WAIT at step 1 → all outputs return to reset values asynchronously; a table write with busy=1 leaves the table unchanged (verified by a later check).
